// File: rtl/muldiv_pkg.sv
// Shared types and ALU opcode constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIVU = 2'b01,
        MD_REMU = 2'b10,
        MD_RSVD = 2'b11
    } md_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_STEP,
        S_DIV_CMP,
        S_DIV_SUB,
        S_DONE
    } state_t;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_GEU = 4'b1011;

endpackage

// File: rtl/muldiv_seq.sv
// Shift-add multiplier and restoring divider that borrow the shared EX ALU for
// every add, subtract and compare; all outputs are registered.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     alu_active,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                 state, state_n;
    md_op_t                 op_q, op_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [DATA_WIDTH-1:0]  prod, prod_n, mcand, mcand_n, mplier, mplier_n;
    logic [DATA_WIDTH-1:0]  rem, rem_n, quo, quo_n, dvsr, dvsr_n;
    logic [DATA_WIDTH-1:0]  result_n, shifted, srca_n, srcb_n;
    logic [OPCODE_LENGTH-1:0] alu_op_n;
    logic                   last;

    always_comb begin
        state_n  = state;
        op_n     = op_q;
        cnt_n    = cnt;
        prod_n   = prod;
        mcand_n  = mcand;
        mplier_n = mplier;
        rem_n    = rem;
        quo_n    = quo;
        dvsr_n   = dvsr;
        result_n = resp_data;
        last     = (cnt == CNT_LAST);
        shifted  = {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};

        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    op_n     = md_op_t'(req_op);
                    cnt_n    = '0;
                    prod_n   = '0;
                    mcand_n  = req_a;
                    mplier_n = req_b;
                    rem_n    = '0;
                    quo_n    = req_a;
                    dvsr_n   = req_b;
                    case (md_op_t'(req_op))
                        MD_MUL:  state_n = S_MUL_STEP;
                        MD_DIVU: begin
                            state_n = (req_b == '0) ? S_DONE : S_DIV_CMP;
                            result_n = '1;
                        end
                        MD_REMU: begin
                            state_n = (req_b == '0) ? S_DONE : S_DIV_CMP;
                            result_n = req_a;
                        end
                        default: begin
                            state_n  = S_DONE;
                            result_n = '0;
                        end
                    endcase
                end
            end
            S_MUL_STEP: begin
                if (mplier[0])
                    prod_n = alu_result;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + CNT_W'(1);
                if (last) begin
                    state_n  = S_DONE;
                    result_n = prod_n;
                end
            end
            S_DIV_CMP: begin
                quo_n = quo << 1;
                rem_n = shifted;
                if (alu_result[0]) begin
                    state_n = S_DIV_SUB;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (last) begin
                        state_n  = S_DONE;
                        result_n = (op_q == MD_REMU) ? rem_n : quo_n;
                    end
                end
            end
            S_DIV_SUB: begin
                rem_n = alu_result;
                quo_n = {quo[DATA_WIDTH-1:1], 1'b1};
                cnt_n = cnt + CNT_W'(1);
                state_n = last ? S_DONE : S_DIV_CMP;
                if (last)
                    result_n = (op_q == MD_REMU) ? rem_n : quo_n;
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_n  = S_IDLE;
                    result_n = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // ALU drive is registered, so it is derived from the state being entered
        alu_op_n = OPCODE_LENGTH'(ALU_NOP);
        srca_n   = '0;
        srcb_n   = '0;
        case (state_n)
            S_MUL_STEP: begin
                alu_op_n = OPCODE_LENGTH'(ALU_ADD);
                srca_n   = prod_n;
                srcb_n   = mcand_n;
            end
            S_DIV_CMP: begin
                alu_op_n = OPCODE_LENGTH'(ALU_GEU);
                srca_n   = {rem_n[DATA_WIDTH-2:0], quo_n[DATA_WIDTH-1]};
                srcb_n   = dvsr_n;
            end
            S_DIV_SUB: begin
                alu_op_n = OPCODE_LENGTH'(ALU_SUB);
                srca_n   = rem_n;
                srcb_n   = dvsr_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= MD_MUL;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            alu_active <= 1'b0;
            alu_op     <= OPCODE_LENGTH'(ALU_NOP);
            alu_srca   <= '0;
            alu_srcb   <= '0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            cnt        <= cnt_n;
            req_ready  <= (state_n == S_IDLE);
            resp_valid <= (state_n == S_DONE);
            resp_data  <= result_n;
            alu_active <= (state_n == S_MUL_STEP) || (state_n == S_DIV_CMP) ||
                          (state_n == S_DIV_SUB);
            alu_op     <= alu_op_n;
            alu_srca   <= srca_n;
            alu_srcb   <= srcb_n;
        end
    end

    always_ff @(posedge clk) begin
        prod   <= prod_n;
        mcand  <= mcand_n;
        mplier <= mplier_n;
        rem    <= rem_n;
        quo    <= quo_n;
        dvsr   <= dvsr_n;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: closes the ALU loop with a behavioural ALU and checks
// results, latency and ALU usage against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        alu_active;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail   = 0;

    // state shared between driver and monitor
    bit          in_flight = 0;
    bit          got = 0;
    int          cyc = 0;
    int          add_cnt = 0;
    int          sub_cnt = 0;
    logic [1:0]  exp_op = 2'b00;
    logic [31:0] exp_data = '0;
    int          exp_lat = 0;
    int          exp_pop = 0;
    logic [3:0]  prev_op = 4'b0000;
    logic [31:0] last_data = '0;

    muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_active (alu_active),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0110: alu_result = alu_srca - alu_srcb;
            4'b1011: alu_result = {31'b0, alu_srca >= alu_srcb};
            default: alu_result = '0;
        endcase
    end

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            2'b00:   return a * b;
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op == 2'b00)
            return 33;
        if ((op == 2'b01 || op == 2'b10) && b != 0)
            return 33 + $countones(a / b);
        return 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_flight) begin
                cyc++;
                if (!got && !resp_valid) begin
                    chk("busy_alu_active", alu_active, 1);
                    chk("busy_req_ready", req_ready, 0);
                    if (exp_op == 2'b00) begin
                        chk("mul_alu_op", alu_op, 4'b0010);
                        add_cnt++;
                    end else if (alu_op == 4'b0110) begin
                        chk("sub_follows_cmp", prev_op, 4'b1011);
                        sub_cnt++;
                    end else begin
                        chk("div_alu_op", alu_op, 4'b1011);
                    end
                    prev_op = alu_op;
                end else if (!got) begin
                    got = 1;
                    last_data = resp_data;
                    chk("latency", cyc, exp_lat);
                    chk("resp_data", resp_data, exp_data);
                    chk("done_alu_idle", alu_active, 0);
                    if (exp_op == 2'b00)
                        chk("mul_add_cycles", add_cnt, 32);
                    else if (exp_lat > 1)
                        chk("div_sub_cycles", sub_cnt, exp_pop);
                end else begin
                    chk("hold_valid", resp_valid, 1);
                    chk("hold_data", resp_data, exp_data);
                    chk("hold_req_ready", req_ready, 0);
                    chk("hold_alu_op", alu_op, 0);
                end
            end else begin
                chk("idle_valid", resp_valid, 0);
                chk("idle_alu_active", alu_active, 0);
                chk("idle_alu_op", alu_op, 0);
                chk("idle_req_ready", req_ready, 1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_alu_active"}, alu_active, 0);
        chk({tag, "_alu_srca"}, alu_srca, 0);
        chk({tag, "_alu_srcb"}, alu_srcb, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_req_ready"}, req_ready, 1);
    endtask

    task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom_range(0, 3));
        req_a = $urandom;
        req_b = $urandom;
        exp_op = op;
        exp_data = model_res(op, a, b);
        exp_lat = model_lat(op, a, b);
        exp_pop = (exp_lat > 1 && op != 2'b00) ? exp_lat - 33 : 0;
        cyc = 0;
        got = 0;
        add_cnt = 0;
        sub_cnt = 0;
        prev_op = 4'b0000;
        in_flight = 1;
    endtask

    task automatic finish_req(input int hold, input bit pulse);
        int t;
        t = 0;
        while (!got && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!got) chk("response_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            req_valid = (pulse && i == 3);
            req_op = 2'b00;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        in_flight = 0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit pulse);
        start_req(op, a, b);
        finish_req(hold, pulse);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("por");

        chk("model_mul_7x6", model_res(2'b00, 7, 6), 32'd42);
        chk("model_divu_100_7", model_res(2'b01, 100, 7), 32'd14);
        chk("model_remu_100_7", model_res(2'b10, 100, 7), 32'd2);
        chk("model_lat_divu_100_7", model_lat(2'b01, 100, 7), 36);

        do_req(2'b00, 32'd7, 32'd6, 0, 0);
        chk("lit_mul_7x6", last_data, 32'd42);
        do_req(2'b00, 32'hFFFF_FFFF, 32'd2, 1, 0);
        chk("lit_mul_wrap", last_data, 32'hFFFF_FFFE);
        do_req(2'b00, 32'h0001_0000, 32'h0001_0000, 0, 0);
        chk("lit_mul_overflow", last_data, 32'h0);
        do_req(2'b01, 32'd100, 32'd7, 0, 0);
        chk("lit_divu", last_data, 32'd14);
        do_req(2'b10, 32'd100, 32'd7, 2, 0);
        chk("lit_remu", last_data, 32'd2);
        do_req(2'b01, 32'd5, 32'd0, 0, 0);
        chk("lit_divu_by0", last_data, 32'hFFFF_FFFF);
        do_req(2'b10, 32'd5, 32'd0, 0, 0);
        chk("lit_remu_by0", last_data, 32'd5);
        do_req(2'b11, 32'd5, 32'd9, 0, 0);
        chk("lit_rsvd", last_data, 32'd0);
        do_req(2'b01, 32'hFFFF_FFFF, 32'd1, 0, 0);
        chk("lit_divu_by1", last_data, 32'hFFFF_FFFF);

        // long consumer stall with a stray request pulse, then a fresh request
        do_req(2'b10, 32'd1234, 32'd10, 10, 1);
        chk("lit_stall_remu", last_data, 32'd4);
        do_req(2'b00, 32'd12, 32'd11, 0, 0);
        chk("lit_after_stall", last_data, 32'd132);

        // reset in the middle of a divide
        start_req(2'b01, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_flight = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        do_req(2'b00, 32'd3, 32'd3, 0, 0);
        chk("lit_mul_after_rst", last_data, 32'd9);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                2:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
            do_req(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
